// File: rtl/sim_result_monitor.sv
// Simulation end-of-test monitor: decodes pass/fail mailbox writes, detects
// timeout and retirement hangs, and collects saturating run statistics.
module sim_result_monitor #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned PASS_ADDR   = 96,
   parameter int unsigned PASS_DATA   = 3,
   parameter int unsigned FAIL_ADDR   = 100,
   parameter int unsigned MAX_CYCLES  = 100000,
   parameter int unsigned HANG_CYCLES = 1024,
   parameter int unsigned CNT_W       = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_enable,
   input  logic              i_mem_we,
   input  logic [ADDR_W-1:0] i_mem_addr,
   input  logic [DATA_W-1:0] i_mem_wdata,
   input  logic              i_ins_vld,
   input  logic              i_pc_stall,
   output logic [2:0]        o_state,
   output logic              o_done,
   output logic              o_pass,
   output logic              o_fail,
   output logic              o_timeout,
   output logic              o_hang,
   output logic [CNT_W-1:0]  o_cycle_cnt,
   output logic [CNT_W-1:0]  o_retire_cnt,
   output logic [CNT_W-1:0]  o_stall_cnt,
   output logic [CNT_W-1:0]  o_write_cnt,
   output logic [DATA_W-1:0] o_fail_code
);

   localparam int unsigned HANG_W = 32;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RUN     = 3'd1,
      S_PASS    = 3'd2,
      S_FAIL    = 3'd3,
      S_TIMEOUT = 3'd4,
      S_HANG    = 3'd5
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               w_fail_cap;
   logic [CNT_W-1:0]   r_cycle_cnt;
   logic [CNT_W-1:0]   r_retire_cnt;
   logic [CNT_W-1:0]   r_stall_cnt;
   logic [CNT_W-1:0]   r_write_cnt;
   logic [HANG_W-1:0]  r_hang_cnt;
   logic [HANG_W-1:0]  w_hang_nxt;
   logic [CNT_W-1:0]   w_cycle_inc;
   logic [DATA_W-1:0]  r_fail_code;
   logic               r_done;
   logic               r_pass;
   logic               r_fail;
   logic               r_timeout;
   logic               r_hang;
   logic               w_start;
   logic               w_run_act;
   logic               w_pass_hit;
   logic               w_fail_hit;
   logic               w_hang_hit;
   logic               w_timeout_hit;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   // Event decode for the current cycle
   assign w_start     = (r_state == S_IDLE) && i_enable;
   assign w_run_act   = (r_state == S_RUN) && i_enable;
   assign w_cycle_inc = sat_inc(r_cycle_cnt);
   assign w_hang_nxt  = i_ins_vld ? '0 :
                        ((r_hang_cnt == {HANG_W{1'b1}}) ? r_hang_cnt : r_hang_cnt + HANG_W'(1));

   assign w_pass_hit = i_mem_we && (i_mem_addr == ADDR_W'(PASS_ADDR))
                                && (i_mem_wdata == DATA_W'(PASS_DATA));
   assign w_fail_hit = i_mem_we && (((i_mem_addr == ADDR_W'(PASS_ADDR))
                                     && (i_mem_wdata != DATA_W'(PASS_DATA)))
                                    || (i_mem_addr == ADDR_W'(FAIL_ADDR)));
   assign w_hang_hit    = (HANG_CYCLES != 0) && (w_hang_nxt == HANG_W'(HANG_CYCLES));
   assign w_timeout_hit = (MAX_CYCLES != 0) && (64'(w_cycle_inc) == 64'(MAX_CYCLES));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state; terminal states only leave through reset
   always_comb begin
      w_state_nxt = r_state;
      w_fail_cap  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_enable) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            if (!i_enable) begin
               w_state_nxt = S_IDLE;
            end else if (w_fail_hit) begin
               w_state_nxt = S_FAIL;
               w_fail_cap  = 1'b1;
            end else if (w_pass_hit) begin
               w_state_nxt = S_PASS;
            end else if (w_hang_hit) begin
               w_state_nxt = S_HANG;
            end else if (w_timeout_hit) begin
               w_state_nxt = S_TIMEOUT;
            end
         end
         S_PASS, S_FAIL, S_TIMEOUT, S_HANG: w_state_nxt = r_state;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Run statistics: cleared on start, advanced only while running
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cycle_cnt  <= '0;
         r_retire_cnt <= '0;
         r_stall_cnt  <= '0;
         r_write_cnt  <= '0;
         r_hang_cnt   <= '0;
      end else if (w_start) begin
         r_cycle_cnt  <= '0;
         r_retire_cnt <= '0;
         r_stall_cnt  <= '0;
         r_write_cnt  <= '0;
         r_hang_cnt   <= '0;
      end else if (w_run_act) begin
         r_cycle_cnt <= w_cycle_inc;
         r_hang_cnt  <= w_hang_nxt;
         if (i_ins_vld)  r_retire_cnt <= sat_inc(r_retire_cnt);
         if (i_pc_stall) r_stall_cnt  <= sat_inc(r_stall_cnt);
         if (i_mem_we)   r_write_cnt  <= sat_inc(r_write_cnt);
      end
   end

   // Status flags track the state being entered so they line up with o_state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_fail      <= 1'b0;
         r_timeout   <= 1'b0;
         r_hang      <= 1'b0;
         r_fail_code <= '0;
      end else begin
         r_pass    <= (w_state_nxt == S_PASS);
         r_fail    <= (w_state_nxt == S_FAIL);
         r_timeout <= (w_state_nxt == S_TIMEOUT);
         r_hang    <= (w_state_nxt == S_HANG);
         r_done    <= (w_state_nxt == S_PASS) || (w_state_nxt == S_FAIL)
                   || (w_state_nxt == S_TIMEOUT) || (w_state_nxt == S_HANG);
         if (w_fail_cap) r_fail_code <= i_mem_wdata;
      end
   end

   assign o_state      = r_state;
   assign o_done       = r_done;
   assign o_pass       = r_pass;
   assign o_fail       = r_fail;
   assign o_timeout    = r_timeout;
   assign o_hang       = r_hang;
   assign o_cycle_cnt  = r_cycle_cnt;
   assign o_retire_cnt = r_retire_cnt;
   assign o_stall_cnt  = r_stall_cnt;
   assign o_write_cnt  = r_write_cnt;
   assign o_fail_code  = r_fail_code;

endmodule

// File: tb/tb_sim_result_monitor.sv
// Bench for sim_result_monitor: three parameterisations share one stimulus
// stream and are checked every cycle against a behavioural model.
module tb_sim_result_monitor;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        t_en = 1'b0, t_we = 1'b0, t_vld = 1'b0, t_stall = 1'b0;
   logic [31:0] t_addr = '0, t_data = '0;

   logic [2:0]  st [3];
   logic        dn [3], ps [3], fl [3], tmo [3], hg [3];
   logic [31:0] fc [3];
   logic [31:0] cy0, rt0, sl0, wc0, cy1, rt1, sl1, wc1;
   logic [3:0]  cy2, rt2, sl2, wc2;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sim_result_monitor u0 (
      .clk(clk), .reset(reset), .i_enable(t_en), .i_mem_we(t_we), .i_mem_addr(t_addr),
      .i_mem_wdata(t_data), .i_ins_vld(t_vld), .i_pc_stall(t_stall), .o_state(st[0]),
      .o_done(dn[0]), .o_pass(ps[0]), .o_fail(fl[0]), .o_timeout(tmo[0]), .o_hang(hg[0]),
      .o_cycle_cnt(cy0), .o_retire_cnt(rt0), .o_stall_cnt(sl0), .o_write_cnt(wc0),
      .o_fail_code(fc[0]));

   sim_result_monitor #(.MAX_CYCLES(20), .HANG_CYCLES(4)) u1 (
      .clk(clk), .reset(reset), .i_enable(t_en), .i_mem_we(t_we), .i_mem_addr(t_addr),
      .i_mem_wdata(t_data), .i_ins_vld(t_vld), .i_pc_stall(t_stall), .o_state(st[1]),
      .o_done(dn[1]), .o_pass(ps[1]), .o_fail(fl[1]), .o_timeout(tmo[1]), .o_hang(hg[1]),
      .o_cycle_cnt(cy1), .o_retire_cnt(rt1), .o_stall_cnt(sl1), .o_write_cnt(wc1),
      .o_fail_code(fc[1]));

   sim_result_monitor #(.MAX_CYCLES(0), .HANG_CYCLES(0), .CNT_W(4)) u2 (
      .clk(clk), .reset(reset), .i_enable(t_en), .i_mem_we(t_we), .i_mem_addr(t_addr),
      .i_mem_wdata(t_data), .i_ins_vld(t_vld), .i_pc_stall(t_stall), .o_state(st[2]),
      .o_done(dn[2]), .o_pass(ps[2]), .o_fail(fl[2]), .o_timeout(tmo[2]), .o_hang(hg[2]),
      .o_cycle_cnt(cy2), .o_retire_cnt(rt2), .o_stall_cnt(sl2), .o_write_cnt(wc2),
      .o_fail_code(fc[2]));

   // Model: parameters and state per instance
   int unsigned m_max [3] = '{100000, 20, 0};
   int unsigned m_hng [3] = '{1024, 4, 0};
   int unsigned m_cw  [3] = '{32, 32, 4};
   int          m_st  [3];
   logic [63:0] m_cyc [3], m_ret [3], m_stl [3], m_wr [3], m_hang [3], m_code [3];

   function automatic logic [63:0] sat(input logic [63:0] v, input int unsigned w);
      logic [63:0] mx;
      mx = (64'd1 << w) - 64'd1;
      return (v < mx) ? v + 64'd1 : v;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_st[k] = 0; m_cyc[k] = 0; m_ret[k] = 0; m_stl[k] = 0;
         m_wr[k] = 0; m_hang[k] = 0; m_code[k] = 0;
      end
   endtask

   // One rising edge of the reference behaviour, using the current inputs
   task automatic model_step();
      bit pass_w, fail_w;
      pass_w = t_we && (t_addr == 32'd96) && (t_data == 32'd3);
      fail_w = t_we && (((t_addr == 32'd96) && (t_data != 32'd3)) || (t_addr == 32'd100));
      for (int k = 0; k < 3; k++) begin
         if (m_st[k] == 0) begin
            if (t_en) begin
               m_st[k] = 1; m_cyc[k] = 0; m_ret[k] = 0; m_stl[k] = 0; m_wr[k] = 0; m_hang[k] = 0;
            end
         end else if (m_st[k] == 1) begin
            if (!t_en) m_st[k] = 0;
            else begin
               m_cyc[k] = sat(m_cyc[k], m_cw[k]);
               if (t_vld)   m_ret[k] = sat(m_ret[k], m_cw[k]);
               if (t_stall) m_stl[k] = sat(m_stl[k], m_cw[k]);
               if (t_we)    m_wr[k]  = sat(m_wr[k], m_cw[k]);
               m_hang[k] = t_vld ? 64'd0 : m_hang[k] + 64'd1;
               if (fail_w) begin
                  m_st[k] = 3; m_code[k] = 64'(t_data);
               end else if (pass_w)
                  m_st[k] = 2;
               else if (m_hng[k] != 0 && m_hang[k] == 64'(m_hng[k]))
                  m_st[k] = 5;
               else if (m_max[k] != 0 && m_cyc[k] == 64'(m_max[k]))
                  m_st[k] = 4;
            end
         end
      end
   endtask

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic cmp_inst(input int k, input logic [63:0] cyc, ret, stl, wrc);
      check($sformatf("u%0d.state", k), 64'(st[k]), 64'(m_st[k]));
      check($sformatf("u%0d.done", k), 64'(dn[k]), 64'(m_st[k] >= 2));
      check($sformatf("u%0d.pass", k), 64'(ps[k]), 64'(m_st[k] == 2));
      check($sformatf("u%0d.fail", k), 64'(fl[k]), 64'(m_st[k] == 3));
      check($sformatf("u%0d.timeout", k), 64'(tmo[k]), 64'(m_st[k] == 4));
      check($sformatf("u%0d.hang", k), 64'(hg[k]), 64'(m_st[k] == 5));
      check($sformatf("u%0d.cycle_cnt", k), cyc, m_cyc[k]);
      check($sformatf("u%0d.retire_cnt", k), ret, m_ret[k]);
      check($sformatf("u%0d.stall_cnt", k), stl, m_stl[k]);
      check($sformatf("u%0d.write_cnt", k), wrc, m_wr[k]);
      check($sformatf("u%0d.fail_code", k), 64'(fc[k]), m_code[k]);
   endtask

   task automatic compare_all();
      cmp_inst(0, 64'(cy0), 64'(rt0), 64'(sl0), 64'(wc0));
      cmp_inst(1, 64'(cy1), 64'(rt1), 64'(sl1), 64'(wc1));
      cmp_inst(2, 64'(cy2), 64'(rt2), 64'(sl2), 64'(wc2));
   endtask

   // Compare at the falling edge, drive, then let the rising edge apply
   task automatic step(input bit e, v, s, w, input logic [31:0] a, d);
      @(negedge clk);
      compare_all();
      #1;
      t_en = e; t_vld = v; t_stall = s; t_we = w; t_addr = a; t_data = d;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic rst_pulse();
      @(negedge clk);
      #1;
      t_en = 0; t_vld = 0; t_stall = 0; t_we = 0; t_addr = '0; t_data = '0;
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      compare_all();
      #1 reset = 1'b0;
   endtask

   initial begin
      model_reset();
      #1 reset = 1'b1;
      #20;
      check("reset_state", 64'(st[0]), 64'd0);
      check("reset_done", 64'(dn[0]), 64'd0);
      check("reset_cycle", 64'(cy0), 64'd0);
      #1 reset = 1'b0;

      // Pass after ten retiring cycles
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0, 0);
      step(1, 1, 0, 1, 32'd96, 32'd3);
      check("pass_state", 64'(st[0]), 64'd2);
      check("pass_flag", 64'(ps[0]), 64'd1);
      check("pass_done", 64'(dn[0]), 64'd1);
      check("pass_retire", 64'(rt0), 64'd11);
      check("pass_writes", 64'(wc0), 64'd1);
      check("pass_u2_retire", 64'(rt2), 64'd11);

      // Fail data is captured and the verdict is sticky
      rst_pulse();
      step(1, 0, 0, 0, 0, 0);
      step(1, 1, 0, 1, 32'd96, 32'd7);
      check("fail_flag", 64'(fl[0]), 64'd1);
      check("fail_code", 64'(fc[0]), 64'd7);
      step(1, 1, 0, 1, 32'd96, 32'd3);
      check("fail_sticky", 64'(st[0]), 64'd3);
      check("fail_no_pass", 64'(ps[0]), 64'd0);

      // Pass beats hang on the same edge; without the write it hangs
      rst_pulse();
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 32'd96, 32'd3);
      check("prio_state", 64'(st[1]), 64'd2);
      check("prio_nohang", 64'(hg[1]), 64'd0);
      rst_pulse();
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
      check("hang_state", 64'(st[1]), 64'd5);
      check("hang_flag", 64'(hg[1]), 64'd1);

      // Timeout after edge 20 with toggling retirement
      rst_pulse();
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 19; i++) step(1, 1'(i % 2), 0, 0, 0, 0);
      check("pre_timeout", 64'(st[1]), 64'd1);
      step(1, 1, 0, 0, 0, 0);
      check("timeout_flag", 64'(tmo[1]), 64'd1);
      check("timeout_cycle", 64'(cy1), 64'd20);

      // Narrow counters saturate
      rst_pulse();
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) step(1, 1, 1, 0, 0, 0);
      check("sat_stall", 64'(sl2), 64'd15);
      check("sat_cycle", 64'(cy2), 64'd15);
      check("wide_stall", 64'(sl0), 64'd20);

      // Disable returns to idle holding counts; re-enable clears
      rst_pulse();
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      check("disable_idle", 64'(st[0]), 64'd0);
      check("disable_hold", 64'(cy0), 64'd5);
      step(1, 0, 0, 0, 0, 0);
      check("restart_clear", 64'(cy0), 64'd0);
      step(1, 1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0);

      // Asynchronous reset between edges
      @(negedge clk);
      compare_all();
      #2 reset = 1'b1;
      model_reset();
      #1;
      check("async_state", 64'(st[0]), 64'd0);
      check("async_cycle", 64'(cy0), 64'd0);
      check("async_retire", 64'(rt0), 64'd0);
      check("async_done", 64'(dn[0]), 64'd0);
      t_en = 0; t_vld = 0;
      @(negedge clk);
      compare_all();
      #1 reset = 1'b0;
      step(1, 1, 0, 0, 0, 0);
      check("rerun_zero", 64'(cy0), 64'd0);
      for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0);
      check("rerun_count", 64'(cy0), 64'd3);

      // Randomised runs
      for (int r = 0; r < 30; r++) begin
         int unsigned len;
         rst_pulse();
         len = $urandom_range(120, 40);
         for (int i = 0; i < int'(len); i++) begin
            bit e, v, s, w;
            logic [31:0] a, d;
            int unsigned sel;
            e = ($urandom % 32) != 0;
            v = ($urandom % 10) < 6;
            s = ($urandom % 4) == 0;
            w = ($urandom % 4) == 0;
            sel = $urandom % 16;
            a = (sel == 0) ? 32'd96 : (sel == 1) ? 32'd100 : (sel == 2) ? 32'd97 : $urandom;
            sel = $urandom % 3;
            d = (sel == 0) ? 32'd3 : (sel == 1) ? 32'd7 : $urandom;
            step(e, v, s, w, a, d);
         end
      end
      @(negedge clk);
      compare_all();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
